// File: rtl/inv_key_expansion.sv
// Reverse AES-128 key schedule: loads the round-10 key and streams round keys
// 10 down to 0 over valid/ready, rebuilding each earlier key from the later one.
module inv_key_expansion #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             done
);
    if (NR != 10 || KEY_W != 128) begin : g_param_check
        $error("inv_key_expansion supports only NR=10 and KEY_W=128");
    end

    typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d;
    logic [3:0]         round_q, round_d;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] w1_prev, w2_prev, w3_prev, w0_prev;
    logic [31:0] rot_word, sub_word;
    logic [7:0]  rcon;

    // Rcon of the round being left; round 0 is never left.
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd1:  rcon = 8'h01;
            4'd2:  rcon = 8'h02;
            4'd3:  rcon = 8'h04;
            4'd4:  rcon = 8'h08;
            4'd5:  rcon = 8'h10;
            4'd6:  rcon = 8'h20;
            4'd7:  rcon = 8'h40;
            4'd8:  rcon = 8'h80;
            4'd9:  rcon = 8'h1b;
            4'd10: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = key_q;
    assign w3_prev  = w3 ^ w2;
    assign w2_prev  = w2 ^ w1;
    assign w1_prev  = w1 ^ w0;
    assign rot_word = {w3_prev[23:0], w3_prev[31:24]};

    subword u_subword (
        .word_i (rot_word),
        .word_o (sub_word)
    );

    assign w0_prev = w0 ^ sub_word ^ {rcon, 24'h0};

    // Handshake: a key transfers on any rising edge where rk_valid & rk_ready;
    // rk_valid depends only on state, so rk_ready never feeds back into it.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd10;
                    state_d = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (rk_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = {w0_prev, w1_prev, w2_prev, w3_prev};
                        round_d = round_q - 4'd1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign busy     = (state_q == ST_EMIT);
    assign rk_valid = (state_q == ST_EMIT);
    assign done     = (state_q == ST_DONE);
    assign rk_out   = key_q;
    assign rk_round = round_q;
endmodule

// SubWord: forward AES S-box on each byte, built as GF(2^8) inverse plus affine map.
module subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse computed as b^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
        x2   = gf_mul(b, b);
        x3   = gf_mul(x2, b);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        inv  = gf_mul(x252, x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    assign word_o = {sbox(word_i[31:24]), sbox(word_i[23:16]),
                     sbox(word_i[15:8]),  sbox(word_i[7:0])};
endmodule

// File: tb/tb_inv_key_expansion.sv
// Bench for inv_key_expansion: FIPS-197 vector, backpressure, ignored restarts,
// mid-stream reset and 1000 random keys against a forward key-expansion model.
`timescale 1ns/1ps
module tb_inv_key_expansion;
    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         done;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;

    logic [7:0]   sbox_t [256];
    logic [127:0] ref_rk [11];
    logic [131:0] exp_q [$];
    logic [131:0] got_q [$];

    inv_key_expansion #(.NR(10), .KEY_W(128)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .done     (done)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: S-box from polynomial arithmetic, forward FIPS-197 expansion
    function automatic logic [7:0] gf_mul_ref(input int a, input int b);
        int p = 0;
        for (int i = 0; i < 8; i++) if ((b >> i) & 1) p = p ^ (a << i);
        for (int i = 14; i >= 8; i--) if ((p >> i) & 1) p = p ^ (32'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int b = 0; b < 256; b++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) if (gf_mul_ref(b, x) == 8'h01) inv = x[7:0];
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                       ^ inv[(i + 7) % 8] ^ c[i];
            sbox_t[b] = s;
        end
    endtask

    task automatic expand_key(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gf_mul_ref(rc, 2);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic load_expected();
        exp_q.delete();
        for (int r = 10; r >= 0; r--) exp_q.push_back({4'(r), ref_rk[r]});
    endtask

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [127:0] k);
        key_in = k;
        start  = 1'b1;
        step();
        start  = 1'b0;
        key_in = $urandom();
    endtask

    // Consumes beats until done; optionally re-pulses start when restart_round is on the bus.
    task automatic drain(input int duty, input int restart_round, input logic [127:0] restart_key,
                         input int budget, output int cycles, output int dones,
                         output int unstable, output bit timeout);
        logic [131:0] held;
        bit holding;
        cycles = 0; dones = 0; unstable = 0; timeout = 1'b0; holding = 1'b0;
        held = '0;
        got_q.delete();
        while (1) begin
            if (done) begin
                dones++;
                break;
            end
            rk_ready = ($urandom_range(99) < duty);
            if (rk_valid && int'(rk_round) == restart_round) begin
                start  = 1'b1;
                key_in = restart_key;
            end else begin
                start = 1'b0;
            end
            if (holding && rk_valid && {rk_round, rk_out} !== held) unstable++;
            if (rk_valid && rk_ready) begin
                got_q.push_back({rk_round, rk_out});
                holding = 1'b0;
            end else if (rk_valid) begin
                holding = 1'b1;
                held    = {rk_round, rk_out};
            end
            step();
            cycles++;
            if (cycles > budget) begin
                timeout = 1'b1;
                break;
            end
        end
        start    = 1'b0;
        rk_ready = 1'b0;
    endtask

    // Tests
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = '0;
        #2;
        checks++;
        if ({busy, rk_valid, done, rk_round, rk_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b valid=%b done=%b round=%0d key=%h want all 0",
                     busy, rk_valid, done, rk_round, rk_out);
        end
        step(); step();
        rst = 1'b0;
        step(); step();
        checks++;
        if ({busy, rk_valid, done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b valid=%b done=%b want 000", busy, rk_valid, done);
        end
    endtask

    task automatic test_fips_stream();
        int cyc, dn, uns;
        bit to;
        expand_key(FIPS_K0);
        load_expected();
        pulse_start(FIPS_K10);
        checks++;
        if (!(rk_valid === 1'b1 && busy === 1'b1 && rk_round === 4'd10 && rk_out === FIPS_K10)) begin
            errors++;
            $display("FAIL fips_first_beat: got valid=%b busy=%b round=%0d key=%h want 1 1 10 %h",
                     rk_valid, busy, rk_round, rk_out, FIPS_K10);
        end
        drain(100, -1, '0, 50, cyc, dn, uns, to);
        checks++;
        if (to || cyc != 11 || got_q.size() != 11) begin
            errors++;
            $display("FAIL fips_timing: got cycles=%0d beats=%0d timeout=%0d want 11 11 0", cyc, got_q.size(), to);
        end
        for (int i = 0; i < 11; i++) begin
            logic [131:0] g;
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL fips_beat%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        checks++;
        if (got_q.size() != 11 || got_q[0] !== {4'd10, FIPS_K10} || got_q[1] !== {4'd9, FIPS_K9}
            || got_q[9] !== {4'd1, FIPS_K1} || got_q[10] !== {4'd0, FIPS_K0}) begin
            errors++;
            $display("FAIL fips_vectors: beats 0/1/9/10 differ from FIPS-197 A.1 values");
        end
        checks++;
        if (!(done === 1'b1 && rk_valid === 1'b0 && busy === 1'b0)) begin
            errors++;
            $display("FAIL fips_done: got done=%b valid=%b busy=%b want 1 0 0", done, rk_valid, busy);
        end
        step();
        checks++;
        if ({done, rk_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL fips_done_pulse: got done=%b valid=%b busy=%b want 000", done, rk_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int cyc, dn, uns, extra_done;
        bit to;
        expand_key(FIPS_K0);
        load_expected();
        pulse_start(FIPS_K10);
        drain(30, -1, '0, 400, cyc, dn, uns, to);
        checks++;
        if (to || uns != 0) begin
            errors++;
            $display("FAIL bp_stable: got unstable=%0d timeout=%0d want 0 0", uns, to);
        end
        for (int i = 0; i < 11; i++) begin
            logic [131:0] g;
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_beat%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        extra_done = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (done || rk_valid) extra_done++;
        end
        checks++;
        if (dn != 1 || extra_done != 0) begin
            errors++;
            $display("FAIL bp_done_once: got dones=%0d extra=%0d want 1 0", dn, extra_done);
        end
    endtask

    task automatic test_restart_ignored();
        int cyc, dn, uns;
        bit to;
        expand_key(FIPS_K0);
        load_expected();
        pulse_start(FIPS_K10);
        drain(100, 5, '0, 50, cyc, dn, uns, to);
        checks++;
        if (to || dn != 1 || got_q.size() != 11) begin
            errors++;
            $display("FAIL restart_count: got beats=%0d dones=%0d timeout=%0d want 11 1 0", got_q.size(), dn, to);
        end
        for (int i = 0; i < 11; i++) begin
            logic [131:0] g;
            g = (i < got_q.size()) ? got_q[i] : 'x;
            checks++;
            if (g !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_beat%0d: got %h want %h", i, g, exp_q[i]);
            end
        end
        step();
    endtask

    task automatic test_reset_mid_stream();
        int n, bad, cyc, dn, uns;
        bit to;
        expand_key(FIPS_K0);
        load_expected();
        pulse_start(FIPS_K10);
        rk_ready = 1'b1;
        n = 0;
        while (!(rk_valid && rk_round == 4'd3) && n < 20) begin
            step();
            n++;
        end
        rk_ready = 1'b0;
        checks++;
        if (rk_round !== 4'd3 || rk_out !== ref_rk[3]) begin
            errors++;
            $display("FAIL rst_reach_r3: got round=%0d key=%h want 3 %h", rk_round, rk_out, ref_rk[3]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, rk_valid, done, rk_round, rk_out} !== '0) begin
            errors++;
            $display("FAIL rst_async: got busy=%b valid=%b done=%b round=%0d key=%h want all 0",
                     busy, rk_valid, done, rk_round, rk_out);
        end
        step();
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (done || rk_valid || busy) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d active cycles after reset want 0", bad);
        end
        pulse_start(FIPS_K10);
        checks++;
        if (!(rk_valid === 1'b1 && rk_round === 4'd10 && rk_out === FIPS_K10)) begin
            errors++;
            $display("FAIL rst_restart: got valid=%b round=%0d key=%h want 1 10 %h", rk_valid, rk_round, rk_out, FIPS_K10);
        end
        drain(100, -1, '0, 50, cyc, dn, uns, to);
        checks++;
        if (to || got_q.size() != 11 || got_q[10] !== {4'd0, FIPS_K0}) begin
            errors++;
            $display("FAIL rst_rerun: got beats=%0d timeout=%0d want 11 0 with round-0 key %h", got_q.size(), to, FIPS_K0);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc, dn, uns;
        bit to;
        logic [127:0] k0;
        for (int run = 0; run < 1000; run++) begin
            k0 = {$urandom(), $urandom(), $urandom(), $urandom()};
            expand_key(k0);
            load_expected();
            pulse_start(ref_rk[10]);
            drain($urandom_range(100, 50), -1, '0, 200, cyc, dn, uns, to);
            checks++;
            if (to || dn != 1 || uns != 0 || got_q.size() != 11) begin
                errors++;
                $display("FAIL b2b_run%0d: beats=%0d dones=%0d unstable=%0d timeout=%0d want 11 1 0 0",
                         run, got_q.size(), dn, uns, to);
            end
            for (int i = 0; i < 11; i++) begin
                logic [131:0] g;
                g = (i < got_q.size()) ? got_q[i] : 'x;
                checks++;
                if (g !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_run%0d_beat%0d: got %h want %h", run, i, g, exp_q[i]);
                end
            end
            // start presented in the done cycle must be dropped
            key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            start  = 1'b1;
            step();
            start  = 1'b0;
            checks++;
            if ({rk_valid, busy, done} !== 3'b000) begin
                errors++;
                $display("FAIL b2b_done_start%0d: got valid=%b busy=%b done=%b want 000", run, rk_valid, busy, done);
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_stream();
        test_backpressure();
        test_restart_ignored();
        test_reset_mid_stream();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
